booth_issue_stage: RTL and testbench

Upstream issue stage for the sequential Booth multiplier. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It launches one multiply at a time with a single-cycle `valid_in` pulse and captures the product when the multiplier's `valid_out` fires. The product is then held in a result register until a downstream valid/ready handshake consumes it.

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_issue_stage_op_fifo.sv | 45 ++++
 rtl/booth_issue_stage.sv | 127 ++++++++++++
 tb/tb_booth_issue_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and default widths for the Booth multiplier issue stage.
package booth_pkg;

    localparam int WIDTH_IN      = 16;
    localparam int WIDTH_PRODUCT = 2 * WIDTH_IN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issue_state_e;

endpackage

// File: rtl/booth_issue_stage_op_fifo.sv
// Synchronous operand FIFO: wrap-bit pointers, occupancy count, no bypass.
module op_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign count   = wptr_q - rptr_q;
    assign full    = (count == FULL_CNT);
    assign empty   = (wptr_q == rptr_q);
    // Full is judged on registered state, so a same-cycle pop never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/booth_issue_stage.sv
// Issue stage: queues operand pairs, launches one Booth multiply at a time,
// and holds each product until the downstream consumer takes it.
module booth_issue_stage #(
    parameter int WIDTH_IN      = booth_pkg::WIDTH_IN,
    parameter int WIDTH_PRODUCT = 2 * WIDTH_IN,
    parameter int DEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [WIDTH_IN-1:0]       op_a,
    input  logic [WIDTH_IN-1:0]       op_b,
    output logic [WIDTH_IN-1:0]       mul_in_a,
    output logic [WIDTH_IN-1:0]       mul_in_b,
    output logic                      mul_valid_in,
    input  logic                      mul_valid_out,
    input  logic [WIDTH_PRODUCT-1:0]  mul_product,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH_PRODUCT-1:0]  res_product,
    output logic [WIDTH_IN-1:0]       res_a,
    output logic [WIDTH_IN-1:0]       res_b,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      err_spurious
);
    import booth_pkg::*;

    issue_state_e               state_q, state_d;
    logic [WIDTH_IN-1:0]        a_q, a_d, b_q, b_d;
    logic [WIDTH_IN-1:0]        res_a_q, res_a_d, res_b_q, res_b_d;
    logic [WIDTH_PRODUCT-1:0]   res_p_q, res_p_d;
    logic                       res_valid_q, res_valid_d;
    logic                       err_q, err_d;

    logic [2*WIDTH_IN-1:0]      fifo_rdata;
    logic                       fifo_full, fifo_empty, fifo_pop;

    op_fifo #(
        .WIDTH (2 * WIDTH_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (op_valid),
        .wdata ({op_a, op_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_p_d     = res_p_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = fifo_rdata[2*WIDTH_IN-1:WIDTH_IN];
                    b_d      = fifo_rdata[WIDTH_IN-1:0];
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_valid_out) begin
                    res_p_d     = mul_product;
                    res_a_d     = a_q;
                    res_b_d     = b_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A done pulse outside WAIT carries no data we can trust; flag it and keep it.
        if (mul_valid_out && state_q != WAIT) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_p_q     <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_p_q     <= res_p_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign op_ready     = !fifo_full;
    assign mul_in_a     = a_q;
    assign mul_in_b     = b_q;
    assign mul_valid_in = (state_q == ISSUE);
    assign res_valid    = res_valid_q;
    assign res_product  = res_p_q;
    assign res_a        = res_a_q;
    assign res_b        = res_b_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_booth_issue_stage.sv
// Directed bench for booth_issue_stage with a latency-17 multiplier model.
module tb_booth_issue_stage;
    localparam int WI = 16;
    localparam int WP = 32;
    localparam int DEPTH = 4;
    localparam int L = 17;

    logic          clk = 1'b0;
    logic          reset, op_valid, op_ready, mul_valid_in, mul_valid_out;
    logic [WI-1:0] op_a, op_b, mul_in_a, mul_in_b, res_a, res_b;
    logic [WP-1:0] mul_product, res_product;
    logic          res_valid, res_ready, err_spurious;
    logic [$clog2(DEPTH):0] fifo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nlaunch = 0;
    int lq[$];
    logic [63:0] rq[$];

    booth_issue_stage #(.WIDTH_IN(WI), .WIDTH_PRODUCT(WP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
        .mul_valid_in(mul_valid_in), .mul_valid_out(mul_valid_out),
        .mul_product(mul_product), .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_a(res_a), .res_b(res_b),
        .fifo_count(fifo_count), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulse L cycles after the launch pulse.
    logic          mbusy = 1'b0;
    int            mcnt = 0;
    logic [WI-1:0] ma = '0, mb = '0;
    logic          spur;
    logic signed [WP-1:0] ea, eb;
    assign ea = WP'($signed(ma));
    assign eb = WP'($signed(mb));
    assign mul_product   = WP'(ea * eb);
    assign mul_valid_out = (mbusy && mcnt == 0) || spur;

    always @(posedge clk) begin
        if (reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (mul_valid_in) begin
            mbusy <= 1'b1;
            mcnt  <= L - 1;
            ma    <= mul_in_a;
            mb    <= mul_in_b;
        end else if (mbusy) begin
            if (mcnt == 0) mbusy <= 1'b0;
            else           mcnt  <= mcnt - 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && mul_valid_in) begin
            nlaunch <= nlaunch + 1;
            lq.push_back(cyc);
        end
        if (!reset && res_valid && res_ready) rq.push_back({res_a, res_b, res_product});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin step(); n++; end
    endtask

    task automatic wait_launch(output int n);
        n = 0;
        while (mul_valid_in !== 1'b1 && n < 300) begin step(); n++; end
    endtask

    initial begin
        int n, nl0, pushed;
        logic acc;
        reset = 1'b1; op_valid = 1'b1; op_a = 16'h00AA; op_b = 16'h0055;
        res_ready = 1'b0; spur = 1'b0;
        step();
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        step();
        reset = 1'b0; op_valid = 1'b0;
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_mvi", 64'(mul_valid_in), 64'd0);
        chk("rst_mina", 64'(mul_in_a), 64'd0);
        chk("rst_minb", 64'(mul_in_b), 64'd0);
        chk("rst_rvalid", 64'(res_valid), 64'd0);
        chk("rst_rprod", 64'(res_product), 64'd0);
        chk("rst_ra", 64'(res_a), 64'd0);
        chk("rst_rb", 64'(res_b), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        step();
        chk("rst_push_dropped", 64'(fifo_count), 64'd0);

        // Single op 3*5
        op_a = 16'd3; op_b = 16'd5; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("single_count_t1", 64'(fifo_count), 64'd1);
        chk("single_mvi_t1", 64'(mul_valid_in), 64'd0);
        step();
        chk("single_mvi_t2", 64'(mul_valid_in), 64'd1);
        chk("single_mina", 64'(mul_in_a), 64'd3);
        chk("single_minb", 64'(mul_in_b), 64'd5);
        chk("single_count_t2", 64'(fifo_count), 64'd0);
        wait_res(n);
        chk("single_res_latency", 64'(n), 64'd18);
        chk("single_prod", 64'(res_product), 64'h0000000F);
        chk("single_ra", 64'(res_a), 64'd3);
        chk("single_rb", 64'(res_b), 64'd5);
        step();
        chk("single_hold", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("single_consumed", 64'(res_valid), 64'd0);

        // Signed pass-through
        op_a = 16'hFFFE; op_b = 16'h0003; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        wait_launch(n);
        chk("signed_launch", 64'(n), 64'd1);
        wait_res(n);
        chk("signed_res_latency", 64'(n), 64'd18);
        chk("signed_prod", 64'(res_product), 64'hFFFFFFFA);
        chk("signed_ra", 64'(res_a), 64'hFFFE);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Full FIFO and back-pressure
        nl0 = nlaunch;
        for (int i = 0; i < 5; i++) begin
            op_a = 16'(2*i + 1); op_b = 16'(2*i + 2); op_valid = 1'b1;
            chk("full_accept", 64'(op_ready), 64'd1);
            step();
        end
        op_valid = 1'b0;
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(op_ready), 64'd0);
        op_a = 16'h0BAD; op_b = 16'h0BAD; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("full_reject", 64'(fifo_count), 64'd4);
        wait_res(n);
        chk("full_hold_valid", 64'(res_valid), 64'd1);
        chk("full_hold_prod", 64'(res_product), 64'd2);
        chk("full_hold_ready", 64'(op_ready), 64'd0);
        chk("full_hold_count", 64'(fifo_count), 64'd4);
        chk("full_one_inflight", 64'(nlaunch - nl0), 64'd1);
        res_ready = 1'b1;
        step();
        chk("full_pop_ready", 64'(op_ready), 64'd0);
        chk("full_pop_count", 64'(fifo_count), 64'd4);
        step();
        chk("full_launch2", 64'(mul_valid_in), 64'd1);
        chk("full_launch2_a", 64'(mul_in_a), 64'd3);
        chk("full_launch2_count", 64'(fifo_count), 64'd3);
        for (int k = 1; k < 5; k++) begin
            if (k > 1) begin
                wait_launch(n);
                chk("full_gap", 64'(n), 64'd2);
            end
            wait_res(n);
            chk("full_res_latency", 64'(n), 64'd18);
            chk("full_order_a", 64'(res_a), 64'(2*k + 1));
            chk("full_order_b", 64'(res_b), 64'(2*k + 2));
            chk("full_order_prod", 64'(res_product), 64'((2*k + 1) * (2*k + 2)));
            chk("full_serial", 64'(nlaunch - nl0), 64'(k + 1));
        end
        repeat (5) step();
        chk("full_drained", 64'(fifo_count), 64'd0);
        chk("full_no_extra", 64'(nlaunch - nl0), 64'd5);
        res_ready = 1'b0;

        // Spurious done in IDLE
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_err", 64'(err_spurious), 64'd1);
        chk("spur_rvalid", 64'(res_valid), 64'd0);
        repeat (5) step();
        chk("spur_sticky", 64'(err_spurious), 64'd1);

        // Reset in WAIT with two ops queued
        for (int i = 0; i < 3; i++) begin
            op_a = 16'(8'h11 * (2*i + 1)); op_b = 16'(8'h11 * (2*i + 2)); op_valid = 1'b1;
            step();
        end
        op_valid = 1'b0;
        step();
        chk("rw_queued", 64'(fifo_count), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_count", 64'(fifo_count), 64'd0);
        chk("rw_rvalid", 64'(res_valid), 64'd0);
        chk("rw_err", 64'(err_spurious), 64'd0);
        chk("rw_mina", 64'(mul_in_a), 64'd0);
        nl0 = nlaunch;
        repeat (40) step();
        chk("rw_no_launch", 64'(nlaunch - nl0), 64'd0);
        chk("rw_still_idle", 64'(res_valid), 64'd0);
        chk("rw_no_err", 64'(err_spurious), 64'd0);

        // Sustained throughput across FIFO wrap
        lq.delete();
        rq.delete();
        res_ready = 1'b1;
        pushed = 0;
        n = 0;
        while (rq.size() < 20 && n < 2000) begin
            op_valid = (pushed < 20);
            op_a = 16'(pushed + 1);
            op_b = 16'(7*pushed + 3);
            acc = op_valid && op_ready;
            step();
            if (acc) pushed++;
            n++;
        end
        op_valid = 1'b0;
        chk("tp_results", 64'(rq.size()), 64'd20);
        chk("tp_launches", 64'(lq.size()), 64'd20);
        for (int i = 1; i < lq.size(); i++)
            chk("tp_spacing", 64'(lq[i] - lq[i-1]), 64'(L + 3));
        for (int i = 0; i < rq.size(); i++)
            chk("tp_result", rq[i], {16'(i + 1), 16'(7*i + 3), 32'((i + 1) * (7*i + 3))});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
